// File: rtl/video_pkg.sv
// Shared types and frame geometry for the video stream aligner.
package video_pkg;

  localparam int H_IMAGE      = 640;
  localparam int V_IMAGE      = 480;
  localparam int FRAME_PIXELS = H_IMAGE * V_IMAGE;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    STREAM   = 2'd2,
    RESYNC   = 2'd3
  } aligner_state_t;

endpackage

// File: rtl/video_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush and level output.
// A written word reaches the head one cycle after the write edge.
module video_sync_fifo #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_vis;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_ptr_vis <= '0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_ptr_vis <= '0;
    end else begin
      if (wr_en_i) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en_i) rd_ptr <= rd_ptr + (AW+1)'(1);
      // Lagging copy of the write pointer gives the extra cycle of write-to-read latency.
      wr_ptr_vis <= wr_ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !flush_i) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr[AW-1:0]];
  assign level_o   = wr_ptr - rd_ptr;
  assign full_o    = (level_o == (AW+1)'(DEPTH));
  assign empty_o   = (wr_ptr_vis == rd_ptr);

endmodule

// File: rtl/video_stream_aligner.sv
// Buffers the captured pixel stream and aligns its frame start to the display frame start.
//   state    | meaning
//   WAIT_SOF | discard pixels until a start-of-frame pixel arrives
//   FILL     | buffer pixels until prefill level is reached at a display frame boundary
//   STREAM   | buffer input and serve pixels to the output stage
//   RESYNC   | flush FIFO and counters after an error, then hunt for SOF again
module video_stream_aligner #(
  parameter int H_IMAGE    = video_pkg::H_IMAGE,
  parameter int V_IMAGE    = video_pkg::V_IMAGE,
  parameter int FIFO_DEPTH = 2048,
  parameter int PREFILL    = 1024,
  parameter int TIMEOUT    = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] pix_data_i,
  input  logic       pix_valid_i,
  input  logic       pix_sof_i,
  input  logic       new_frame_i,
  input  logic       rdreq_i,
  output logic [7:0] rddata_o,
  output logic       video_valid_o,
  output logic       overflow_o,
  output logic       underflow_o,
  output logic       frame_err_o
);
  import video_pkg::*;

  localparam int FRAME_CNT = H_IMAGE * V_IMAGE;
  localparam int CW        = $clog2(FRAME_CNT + 1);
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);

  aligner_state_t state, state_nxt;
  logic [CW-1:0]  pix_cnt, pix_cnt_nxt;
  logic [TW-1:0]  tmo_cnt, tmo_cnt_nxt;

  logic           fifo_wr, fifo_rd, fifo_flush;
  logic           fifo_empty, fifo_full;
  logic [AW:0]    fifo_level;
  logic [7:0]     fifo_head;
  logic           ovf, unf, ferr, tmo_hit, sof;

  video_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (fifo_flush),
    .wr_en_i   (fifo_wr),
    .wr_data_i (pix_data_i),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .level_o   (fifo_level)
  );

  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    tmo_cnt_nxt = (tmo_cnt == TW'(TIMEOUT)) ? tmo_cnt : tmo_cnt + TW'(1);
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;
    fifo_flush  = 1'b0;
    ovf         = 1'b0;
    unf         = 1'b0;
    ferr        = 1'b0;
    tmo_hit     = 1'b0;
    sof         = pix_valid_i && pix_sof_i;

    if (sof) tmo_cnt_nxt = '0;

    case (state)
      WAIT_SOF: begin
        if (sof) begin
          fifo_wr     = 1'b1;
          pix_cnt_nxt = CW'(1);
          state_nxt   = FILL;
        end
      end
      FILL, STREAM: begin
        tmo_hit = (tmo_cnt == TW'(TIMEOUT));
        if (pix_valid_i) begin
          if (pix_sof_i && (pix_cnt != CW'(FRAME_CNT))) begin
            ferr = 1'b1;
          end else if (fifo_full) begin
            ovf = 1'b1;
          end else begin
            fifo_wr = 1'b1;
            if (pix_sof_i)              pix_cnt_nxt = CW'(1);
            else if (pix_cnt != '1)     pix_cnt_nxt = pix_cnt + CW'(1);
          end
        end
        if ((state == STREAM) && rdreq_i) begin
          if (fifo_empty) unf     = 1'b1;
          else            fifo_rd = 1'b1;
        end
        // All error causes share a single RESYNC transition.
        if (ovf || unf || ferr || tmo_hit) begin
          state_nxt = RESYNC;
        end else if ((state == FILL) && new_frame_i && (fifo_level >= (AW+1)'(PREFILL))) begin
          state_nxt = STREAM;
        end
      end
      RESYNC: begin
        fifo_flush  = 1'b1;
        pix_cnt_nxt = '0;
        tmo_cnt_nxt = '0;
        state_nxt   = WAIT_SOF;
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= WAIT_SOF;
      pix_cnt       <= '0;
      tmo_cnt       <= '0;
      video_valid_o <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      state         <= state_nxt;
      pix_cnt       <= pix_cnt_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
      video_valid_o <= (state_nxt == STREAM);
      overflow_o    <= ovf;
      underflow_o   <= unf;
      frame_err_o   <= ferr;
    end
  end

  assign rddata_o = ((state == STREAM) && !fifo_empty) ? fifo_head : 8'h00;

endmodule

// File: tb/tb_video_stream_aligner.sv
// Directed bench for video_stream_aligner using a scaled-down frame, FIFO and timeout.
module tb_video_stream_aligner;

  localparam int H_IMG   = 2;
  localparam int V_IMG   = 4;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
  localparam int TMO     = 60;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] pix_data_i;
  logic       pix_valid_i;
  logic       pix_sof_i;
  logic       new_frame_i;
  logic       rdreq_i;
  logic [7:0] rddata_o;
  logic       video_valid_o;
  logic       overflow_o;
  logic       underflow_o;
  logic       frame_err_o;

  int vectors = 0;
  int miscompares = 0;

  video_stream_aligner #(
    .H_IMAGE    (H_IMG),
    .V_IMAGE    (V_IMG),
    .FIFO_DEPTH (DEPTH),
    .PREFILL    (PREFILL),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pix_data_i    (pix_data_i),
    .pix_valid_i   (pix_valid_i),
    .pix_sof_i     (pix_sof_i),
    .new_frame_i   (new_frame_i),
    .rdreq_i       (rdreq_i),
    .rddata_o      (rddata_o),
    .video_valid_o (video_valid_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .frame_err_o   (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    pix_valid_i = 1'b1;
    pix_data_i  = d;
    pix_sof_i   = s;
    step();
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
  endtask

  task automatic frame_pulse();
    new_frame_i = 1'b1;
    step();
    new_frame_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i     = 1'b0;
    pix_data_i  = 8'h00;
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
    new_frame_i = 1'b0;
    rdreq_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i     = 1'b0;
    pix_data_i  = 8'h00;
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
    new_frame_i = 1'b0;
    rdreq_i     = 1'b0;
    #23;
    vectors++;
    if ({video_valid_o, overflow_o, underflow_o, frame_err_o, rddata_o} !== 12'h000) begin
      $display("FAIL reset_outputs: got %h expected 000",
               {video_valid_o, overflow_o, underflow_o, frame_err_o, rddata_o});
      miscompares++;
    end
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    pix_valid_i = 1'b1;
    pix_data_i  = 8'hEE;
    for (int i = 0; i < 100; i++) begin
      step();
      vectors++;
      if ({video_valid_o, overflow_o, underflow_o, frame_err_o, rddata_o} !== 12'h000) begin
        $display("FAIL wait_sof_discard cycle %0d: got %h expected 000", i,
                 {video_valid_o, overflow_o, underflow_o, frame_err_o, rddata_o});
        miscompares++;
      end
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic test_fill_stream();
    push(8'h11, 1'b1);
    vectors++;
    if (video_valid_o !== 1'b0) begin
      $display("FAIL fill_vv_low: got %b expected 0", video_valid_o);
      miscompares++;
    end
    for (int i = 1; i < 8; i++) push(8'h11 + 8'(i), 1'b0);
    frame_pulse();
    vectors++;
    if (video_valid_o !== 1'b1) begin
      $display("FAIL stream_vv_rise: got %b expected 1", video_valid_o);
      miscompares++;
    end
    rdreq_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rddata_o !== 8'h11 + 8'(i)) begin
        $display("FAIL stream_read %0d: got %h expected %h", i, rddata_o, 8'h11 + 8'(i));
        miscompares++;
      end
      step();
    end
    rdreq_i = 1'b0;
    vectors++;
    if ({video_valid_o, rddata_o} !== {1'b1, 8'h14}) begin
      $display("FAIL stream_head_after_reads: got %h expected 114", {video_valid_o, rddata_o});
      miscompares++;
    end
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({video_valid_o, rddata_o} !== 9'h000) begin
      $display("FAIL reset_midframe: got %h expected 000", {video_valid_o, rddata_o});
      miscompares++;
    end
  endtask

  task automatic test_prefill_short();
    do_reset();
    push(8'h21, 1'b1);
    for (int i = 1; i < 7; i++) push(8'h21 + 8'(i), 1'b0);
    frame_pulse();
    vectors++;
    if (video_valid_o !== 1'b0) begin
      $display("FAIL prefill_minus1: got %b expected 0", video_valid_o);
      miscompares++;
    end
    push(8'h28, 1'b0);
    frame_pulse();
    vectors++;
    if ({video_valid_o, rddata_o} !== {1'b1, 8'h21}) begin
      $display("FAIL prefill_reached: got %h expected 121", {video_valid_o, rddata_o});
      miscompares++;
    end
  endtask

  task automatic test_underflow();
    rdreq_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rddata_o !== 8'h21 + 8'(i)) begin
        $display("FAIL drain %0d: got %h expected %h", i, rddata_o, 8'h21 + 8'(i));
        miscompares++;
      end
      if (i == 7) begin
        pix_valid_i = 1'b1;
        pix_data_i  = 8'h29;
      end
      step();
    end
    rdreq_i     = 1'b0;
    pix_valid_i = 1'b0;
    vectors++;
    if (rddata_o !== 8'h00) begin
      $display("FAIL write_latency_hidden: got %h expected 00", rddata_o);
      miscompares++;
    end
    step();
    vectors++;
    if (rddata_o !== 8'h29) begin
      $display("FAIL write_latency_visible: got %h expected 29", rddata_o);
      miscompares++;
    end
    rdreq_i = 1'b1;
    step();
    vectors++;
    if ({underflow_o, rddata_o} !== 9'h000) begin
      $display("FAIL drained_empty: got %h expected 000", {underflow_o, rddata_o});
      miscompares++;
    end
    step();
    vectors++;
    if ({underflow_o, video_valid_o} !== 2'b10) begin
      $display("FAIL underflow_pulse: got %b expected 10", {underflow_o, video_valid_o});
      miscompares++;
    end
    rdreq_i = 1'b0;
    step();
    vectors++;
    if ({underflow_o, video_valid_o, rddata_o} !== 10'h000) begin
      $display("FAIL underflow_end: got %h expected 000", {underflow_o, video_valid_o, rddata_o});
      miscompares++;
    end
    push(8'h99, 1'b0);
    push(8'h30, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h30 + 8'(i), 1'b0);
    frame_pulse();
    vectors++;
    if ({video_valid_o, rddata_o} !== {1'b1, 8'h30}) begin
      $display("FAIL resync_restart: got %h expected 130", {video_valid_o, rddata_o});
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push(8'h50, 1'b1);
    for (int i = 1; i < 16; i++) push(8'h50 + 8'(i), 1'b0);
    vectors++;
    if (overflow_o !== 1'b0) begin
      $display("FAIL full_no_overflow: got %b expected 0", overflow_o);
      miscompares++;
    end
    push(8'h60, 1'b0);
    vectors++;
    if ({overflow_o, video_valid_o} !== 2'b10) begin
      $display("FAIL overflow_pulse: got %b expected 10", {overflow_o, video_valid_o});
      miscompares++;
    end
    step();
    vectors++;
    if (overflow_o !== 1'b0) begin
      $display("FAIL overflow_one_cycle: got %b expected 0", overflow_o);
      miscompares++;
    end
    push(8'h70, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h70 + 8'(i), 1'b0);
    frame_pulse();
    vectors++;
    if ({video_valid_o, rddata_o} !== {1'b1, 8'h70}) begin
      $display("FAIL overflow_flushed: got %h expected 170", {video_valid_o, rddata_o});
      miscompares++;
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    push(8'h40, 1'b1);
    for (int i = 1; i < 7; i++) push(8'h40 + 8'(i), 1'b0);
    push(8'h47, 1'b1);
    vectors++;
    if ({frame_err_o, video_valid_o} !== 2'b10) begin
      $display("FAIL sof_short_frame: got %b expected 10", {frame_err_o, video_valid_o});
      miscompares++;
    end
    step();
    vectors++;
    if (frame_err_o !== 1'b0) begin
      $display("FAIL frame_err_one_cycle: got %b expected 0", frame_err_o);
      miscompares++;
    end
    push(8'h40, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h40 + 8'(i), 1'b0);
    push(8'h48, 1'b1);
    vectors++;
    if (frame_err_o !== 1'b0) begin
      $display("FAIL sof_exact_frame: got %b expected 0", frame_err_o);
      miscompares++;
    end
    frame_pulse();
    rdreq_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 8'h49 + 8'(i);
      vectors++;
      if (rddata_o !== 8'h40 + 8'(i)) begin
        $display("FAIL rw_same_cycle %0d: got %h expected %h", i, rddata_o, 8'h40 + 8'(i));
        miscompares++;
      end
      step();
    end
    vectors++;
    if (rddata_o !== 8'h47) begin
      $display("FAIL rw_same_cycle 7: got %h expected 47", rddata_o);
      miscompares++;
    end
    pix_data_i = 8'h50;
    pix_sof_i  = 1'b1;
    step();
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
    rdreq_i     = 1'b0;
    vectors++;
    if ({frame_err_o, video_valid_o} !== 2'b01) begin
      $display("FAIL sof_after_restart_count: got %b expected 01", {frame_err_o, video_valid_o});
      miscompares++;
    end
    push(8'h51, 1'b0);
    push(8'h52, 1'b0);
    push(8'h53, 1'b1);
    vectors++;
    if ({frame_err_o, video_valid_o} !== 2'b10) begin
      $display("FAIL sof_early_in_stream: got %b expected 10", {frame_err_o, video_valid_o});
      miscompares++;
    end
  endtask

  task automatic test_cnt_saturate();
    do_reset();
    push(8'h60, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h60 + 8'(i), 1'b0);
    frame_pulse();
    rdreq_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 8'h68 + 8'(i);
      step();
    end
    pix_valid_i = 1'b0;
    rdreq_i     = 1'b0;
    vectors++;
    if ({frame_err_o, underflow_o, overflow_o, video_valid_o} !== 4'b0001) begin
      $display("FAIL long_frame_streaming: got %b expected 0001",
               {frame_err_o, underflow_o, overflow_o, video_valid_o});
      miscompares++;
    end
    push(8'h80, 1'b1);
    vectors++;
    if ({frame_err_o, video_valid_o} !== 2'b10) begin
      $display("FAIL sof_long_frame: got %b expected 10", {frame_err_o, video_valid_o});
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push(8'h90, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h90 + 8'(i), 1'b0);
    frame_pulse();
    repeat (TMO - 8) step();
    vectors++;
    if (video_valid_o !== 1'b1) begin
      $display("FAIL timeout_not_yet: got %b expected 1", video_valid_o);
      miscompares++;
    end
    step();
    vectors++;
    if ({video_valid_o, overflow_o, underflow_o, frame_err_o} !== 4'b0000) begin
      $display("FAIL timeout_drop: got %b expected 0000",
               {video_valid_o, overflow_o, underflow_o, frame_err_o});
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_prefill_short();
    test_underflow();
    test_overflow();
    test_frame_err();
    test_cnt_saturate();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
